// File: rtl/calculadora_multiciclo_if.sv
// calculadora_multiciclo_if: start/status handshake, ROM fetch and
// register readback bundle of the multi-cycle calculator.
interface calculadora_multiciclo_if #(
    parameter int W  = 32,
    parameter int PW = 4
);
    logic          start;
    logic [PW-1:0] instr_addr;
    logic [31:0]   instr_data;
    logic [4:0]    rd_addr;
    logic [W-1:0]  rd_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          ovf;

    modport master (
        output start, instr_data, rd_addr,
        input  instr_addr, rd_data, busy, done, error, ovf
    );

    modport slave (
        input  start, instr_data, rd_addr,
        output instr_addr, rd_data, busy, done, error, ovf
    );
endinterface

// File: rtl/calculadora_multiciclo.sv
// calculadora_multiciclo: multi-cycle RV32I ALU-subset calculator.
// Define CALC_OVF_TRAP_EN to trap (no write, error=1) on signed overflow.
module calculadora_multiciclo #(
    parameter int W          = 32,
    parameter int PROG_DEPTH = 16,
    parameter int NREGS      = 32
) (
    input  logic clock,
    input  logic reset,
    calculadora_multiciclo_if.slave bus
);
    localparam int PW = $clog2(PROG_DEPTH);
    localparam int RB = $clog2(NREGS);
    localparam logic [PW-1:0] PC_LAST = PW'(PROG_DEPTH - 1);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

`ifdef CALC_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [PW-1:0] pc;
    logic [31:0]   ir;
    logic [W-1:0]  a, b, res;
    logic          res_ovf;
    logic          error, ovf;
    logic          busy, done;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  regs [NREGS];

    logic [6:0]    op, f7;
    logic [2:0]    f3;
    logic          is_r, is_i, is_halt, is_sub;
    logic          f3_ok, f7_ok, legal;
    logic [RB-1:0] rd_i, rs1_i, rs2_i;
    logic [W-1:0]  imm;

    assign op      = ir[6:0];
    assign f3      = ir[14:12];
    assign f7      = ir[31:25];
    assign rd_i    = ir[7 +: RB];
    assign rs1_i   = ir[15 +: RB];
    assign rs2_i   = ir[20 +: RB];
    assign imm     = {{(W-12){ir[31]}}, ir[31:20]};
    assign is_r    = (op == OP_R);
    assign is_i    = (op == OP_I);
    assign is_halt = (ir == 32'h0);
    assign is_sub  = is_r && ir[30];
    assign f3_ok   = f3 inside {3'b000, 3'b100, 3'b110, 3'b111, 3'b010};
    assign f7_ok   = (f7 == 7'b0000000)
                  || (f7 == 7'b0100000 && f3 == 3'b000);
    assign legal   = (is_i && f3_ok) || (is_r && f3_ok && f7_ok);

    logic [W-1:0] sum, diff, alu_res;
    logic         lt, alu_ovf;

    assign sum  = a + b;
    assign diff = a - b;
    assign lt   = $signed(a) < $signed(b);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (1'b1)
            (f3 == 3'b000) && !is_sub: begin
                alu_res = sum;
                alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            (f3 == 3'b000) && is_sub: begin
                alu_res = diff;
                alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            f3 == 3'b100: alu_res = a ^ b;
            f3 == 3'b110: alu_res = a | b;
            f3 == 3'b111: alu_res = a & b;
            f3 == 3'b010: alu_res = {{(W-1){1'b0}}, lt};
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: if (bus.start) state_nx = S_FETCH;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = (is_halt || !legal) ? S_DONE : S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB: begin
                if ((TRAP && res_ovf) || pc == PC_LAST) state_nx = S_DONE;
                else                                     state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_FETCH, S_DECODE, S_EXEC, S_WB: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            res     <= '0;
            res_ovf <= 1'b0;
            error   <= 1'b0;
            ovf     <= 1'b0;
            rd_data <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            rd_data <= regs[bus.rd_addr[RB-1:0]];
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        pc    <= '0;
                        error <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                S_FETCH: ir <= bus.instr_data;
                S_DECODE: begin
                    a <= regs[rs1_i];
                    b <= is_r ? regs[rs2_i] : imm;
                    if (!is_halt && !legal) error <= 1'b1;
                end
                S_EXEC: begin
                    res     <= alu_res;
                    res_ovf <= alu_ovf;
                    ovf     <= ovf | alu_ovf;
                end
                S_WB: begin
                    // a trapped word keeps pc pointing at itself
                    if (TRAP && res_ovf) begin
                        error <= 1'b1;
                    end else begin
                        if (rd_i != '0) regs[rd_i] <= res;
                        if (pc != PC_LAST) pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_addr = pc;
    assign bus.rd_data    = rd_data;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;
    assign bus.ovf        = ovf;
endmodule

// File: tb/tb_calculadora_multiciclo.sv
// tb_calculadora_multiciclo: directed programs plus random ALU programs
// checked against an arithmetic reference model of the register file.
module tb_calculadora_multiciclo;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    logic [31:0] rom [16];

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_XOR = 3'b100;
    localparam logic [2:0] F_OR  = 3'b110;
    localparam logic [2:0] F_AND = 3'b111;
    localparam logic [2:0] F_SLT = 3'b010;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam longint MAXS = 2147483647;
    localparam longint MINS = -MAXS - 1;

    logic [2:0] f3t [11] = '{F_ADD, F_ADD, F_XOR, F_OR, F_AND, F_SLT,
                             F_ADD, F_XOR, F_OR, F_AND, F_SLT};

    calculadora_multiciclo_if #(.W(32), .PW(4)) bus ();

    calculadora_multiciclo #(
        .W(32), .PROG_DEPTH(16), .NREGS(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    assign bus.instr_data = rom[bus.instr_addr];

    function automatic logic [31:0] ienc(input logic [2:0] f3,
            input int rd, input int rs1, input logic [11:0] imm);
        return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] renc(input logic [6:0] f7,
            input logic [2:0] f3, input int rd, input int rs1,
            input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
            input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkreg(input string tag, input int r,
            input logic [31:0] exp);
        @(negedge clock);
        bus.rd_addr = 5'(r);
        @(posedge clock);
        #1;
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
    endtask

    // poke >= 0 raises start again in the middle of the run
    task automatic run(input int poke, output int cyc);
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 500) begin
            if (cyc == poke) bus.start = 1'b1;
            @(posedge clock);
            #1;
            bus.start = 1'b0;
            cyc++;
        end
        chk("done", 32'(bus.done), 32'h1);
    endtask

    initial begin
        int cyc;
        int k, rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] mreg [32];
        logic [31:0] ma, mb, mr;
        longint s;
        logic ov, mov, merr, stopped;

        bus.start   = 1'b0;
        bus.rd_addr = 5'd0;
        clear_rom();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_error", 32'(bus.error), 32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'h0);
        chk("rst_pc", 32'(bus.instr_addr), 32'h0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // program 1
        clear_rom();
        rom[0] = ienc(F_ADD, 1, 0, 12'd5);
        rom[1] = ienc(F_ADD, 2, 0, 12'hFFD);
        rom[2] = renc(7'h0, F_ADD, 3, 1, 2);
        run(-1, cyc);
        chk("t1_cycles", 32'(cyc), 32'd14);
        chk("t1_error", 32'(bus.error), 32'h0);
        chkreg("t1_x1", 1, 32'd5);
        chkreg("t1_x2", 2, 32'hFFFF_FFFD);
        chkreg("t1_x3", 3, 32'd2);

        // program 2: registers persist across starts
        clear_rom();
        rom[0] = renc(F7_SUB, F_ADD, 4, 2, 1);
        rom[1] = renc(7'h0, F_SLT, 5, 2, 1);
        rom[2] = ienc(F_ADD, 0, 0, 12'd7);
        run(-1, cyc);
        chk("t2_cycles", 32'(cyc), 32'd14);
        chk("t2_ovf", 32'(bus.ovf), 32'h0);
        chkreg("t2_x4", 4, 32'hFFFF_FFF8);
        chkreg("t2_x5", 5, 32'd1);
        chkreg("t2_x0", 0, 32'd0);

        // overflow: build 0x7FFFFFFF by doubling, then double once more
        clear_rom();
        rom[0] = ienc(F_ADD, 1, 0, 12'd1);
        for (int i = 1; i < 15; i++) rom[i] = renc(7'h0, F_ADD, 1, 1, 1);
        run(-1, cyc);
        chk("t3a_cycles", 32'(cyc), 32'd62);
        chkreg("t3a_x1", 1, 32'h0000_4000);
        clear_rom();
        for (int i = 0; i < 15; i++) rom[i] = renc(7'h0, F_ADD, 1, 1, 1);
        run(-1, cyc);
        chk("t3b_ovf", 32'(bus.ovf), 32'h0);
        chkreg("t3b_x1", 1, 32'h2000_0000);
        clear_rom();
        rom[0] = renc(7'h0, F_ADD, 1, 1, 1);
        rom[1] = ienc(F_ADD, 2, 1, 12'hFFF);
        rom[2] = renc(7'h0, F_ADD, 1, 1, 2);
        rom[3] = renc(7'h0, F_ADD, 1, 1, 1);
        run(-1, cyc);
        chk("t3c_ovf", 32'(bus.ovf), 32'h1);
`ifdef CALC_OVF_TRAP_EN
        chk("t3c_error", 32'(bus.error), 32'h1);
        chk("t3c_pc", 32'(bus.instr_addr), 32'd3);
        chkreg("t3c_x1", 1, 32'h7FFF_FFFF);
`else
        chk("t3c_error", 32'(bus.error), 32'h0);
        chkreg("t3c_x1", 1, 32'hFFFF_FFFE);
`endif

        // illegal load opcode at pc=2
        clear_rom();
        rom[0] = ienc(F_ADD, 6, 0, 12'd11);
        rom[1] = ienc(F_ADD, 7, 0, 12'd22);
        rom[2] = 32'h0000_2403;
        rom[3] = ienc(F_ADD, 8, 0, 12'd33);
        run(-1, cyc);
        chk("t4_cycles", 32'(cyc), 32'd10);
        chk("t4_error", 32'(bus.error), 32'h1);
        chk("t4_pc", 32'(bus.instr_addr), 32'd2);
        chkreg("t4_x6", 6, 32'd11);
        chkreg("t4_x7", 7, 32'd22);
        chkreg("t4_x8", 8, 32'd0);

        // asynchronous reset while the 2nd instruction executes
        clear_rom();
        rom[0] = ienc(F_ADD, 1, 0, 12'd5);
        rom[1] = ienc(F_ADD, 2, 0, 12'hFFD);
        rom[2] = renc(7'h0, F_ADD, 3, 1, 2);
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("t5_busy_before", 32'(bus.busy), 32'h1);
        chk("t5_pc_before", 32'(bus.instr_addr), 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_busy", 32'(bus.busy), 32'h0);
        chk("t5_pc", 32'(bus.instr_addr), 32'd0);
        chk("t5_ovf", 32'(bus.ovf), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        chkreg("t5_x6", 6, 32'd0);
        run(-1, cyc);
        chk("t5_cycles", 32'(cyc), 32'd14);
        chkreg("t5_x3", 3, 32'd2);

        // 16 words without HALT, with a start pulse while busy
        for (int i = 0; i < 16; i++) rom[i] = ienc(F_ADD, 9, 9, 12'd1);
        run(10, cyc);
        chk("t6_cycles", 32'(cyc), 32'd64);
        chk("t6_pc", 32'(bus.instr_addr), 32'd15);
        chk("t6_error", 32'(bus.error), 32'h0);
        chkreg("t6_x9", 9, 32'd16);

        // random programs against the reference model
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
        for (int p = 0; p < 4; p++) begin
            mov = 1'b0;
            merr = 1'b0;
            stopped = 1'b0;
            clear_rom();
            for (int i = 0; i < 15; i++) begin
                k   = int'($urandom_range(0, 10));
                rd  = int'($urandom_range(0, 7));
                rs1 = int'($urandom_range(0, 7));
                rs2 = int'($urandom_range(0, 7));
                imm = 12'($urandom);
                if (k < 6)
                    rom[i] = renc(k == 1 ? F7_SUB : 7'h0, f3t[k], rd, rs1, rs2);
                else
                    rom[i] = ienc(f3t[k], rd, rs1, imm);
                ma = mreg[rs1];
                mb = (k < 6) ? mreg[rs2] : {{20{imm[11]}}, imm};
                ov = 1'b0;
                case (k)
                    0, 6: begin
                        s  = longint'($signed(ma)) + longint'($signed(mb));
                        mr = s[31:0];
                        ov = (s > MAXS) || (s < MINS);
                    end
                    1: begin
                        s  = longint'($signed(ma)) - longint'($signed(mb));
                        mr = s[31:0];
                        ov = (s > MAXS) || (s < MINS);
                    end
                    2, 7: mr = ma ^ mb;
                    3, 8: mr = ma | mb;
                    4, 9: mr = ma & mb;
                    default: mr = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
                endcase
                if (!stopped) begin
                    mov = mov | ov;
`ifdef CALC_OVF_TRAP_EN
                    if (ov) begin
                        stopped = 1'b1;
                        merr = 1'b1;
                    end
`endif
                    if (!stopped && rd != 0) mreg[rd] = mr;
                end
            end
            run(-1, cyc);
            if (!stopped) chk("rnd_cycles", 32'(cyc), 32'd62);
            chk("rnd_ovf", 32'(bus.ovf), 32'(mov));
            chk("rnd_error", 32'(bus.error), 32'(merr));
            for (int r = 0; r < 8; r++)
                chkreg($sformatf("rnd%0d_x%0d", p, r), r, mreg[r]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
